// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB completer with a byte-wide register memory and programmable wait states
// Transfers complete after WAIT_STATES stalled access cycles; addresses at or beyond MEM_DEPTH return an error.
module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = MEM_DEPTH[ADDR_WIDTH:0];
  localparam logic [3:0] WS_L = WAIT_STATES[3:0];

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic                  addr_err_q, addr_err_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic             ready_c;
  logic             mem_we;

  assign in_range = ({1'b0, PADDR} < DEPTH_L);
  assign idx      = PADDR[IDX_W-1:0];

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_err_d = addr_err_q;
    prdata_d   = prdata_q;
    mem_we     = 1'b0;
    ready_c    = (state_q == ACCESS) && PSEL && PENABLE && (wait_cnt_q == WS_L);
    case (state_q)
      IDLE: begin
        // PENABLE high without a preceding setup cycle is not a transfer.
        if (PSEL && !PENABLE) begin
          state_d    = ACCESS;
          addr_err_d = !in_range;
          prdata_d   = in_range ? mem_q[idx] : '0;
          wait_cnt_d = '0;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (ready_c) begin
          state_d = IDLE;
          mem_we  = PWRITE && !addr_err_q;
        end else if (wait_cnt_q < WS_L) begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      addr_err_q <= 1'b0;
      prdata_q   <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      addr_err_q <= addr_err_d;
      prdata_q   <= prdata_d;
      if (mem_we) begin
        mem_q[idx] <= PWDATA;
      end
    end
  end

  // Reset must mask the combinational completion even if the FSM sits in ACCESS.
  assign PREADY  = ready_c && !PRESET;
  assign PSLVERR = PREADY && addr_err_q;
  assign PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb/tb_apb_slave_mem.sv - scoreboard bench for apb_slave_mem with zero and two wait states
// Two instances share the bus; psel picks which one a transfer targets.
module tb_apb_slave_mem;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       PENABLE;
  logic       PWRITE;
  logic [1:0] psel;
  logic [7:0] PADDR;
  logic [7:0] PWDATA;
  logic [1:0] pready;
  logic [1:0] pslverr;
  logic [7:0] prdata [2];

  always #5 PCLK = ~PCLK;

  apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(64), .WAIT_STATES(0)) u_dut0 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[0]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0])
  );

  apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(64), .WAIT_STATES(2)) u_dut1 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[1]), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1])
  );

  typedef struct {
    int         dut;
    bit         is_read;
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t       exp_q [$];
  logic [7:0] model [2][64];
  int         n_cmp = 0;
  int         n_mis = 0;

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 64; a++)
        model[d][a] = 8'h00;
  endtask

  // Entered just after a rising edge; leaves just after the completion edge.
  task automatic apb_xfer(input int d, input bit wr, input logic [7:0] addr, input logic [7:0] data);
    exp_t e;
    int   waits;
    bit   done;
    e.dut     = d;
    e.is_read = !wr;
    e.err     = (addr >= 8'd64);
    e.rdata   = e.err ? 8'h00 : model[d][addr[5:0]];
    exp_q.push_back(e);
    if (wr && !e.err) model[d][addr[5:0]] = data;
    psel[d] = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
    @(negedge PCLK);
    check_eq("setup_pready", {31'd0, pready[d]}, 32'd0);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    waits = 0;
    done  = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge PCLK);
      if (pready[d]) begin
        done = 1'b1;
        e = exp_q.pop_front();
        check_eq("wait_states", waits, ws_of(e.dut));
        check_eq("pslverr", {31'd0, pslverr[e.dut]}, {31'd0, e.err});
        if (e.is_read) check_eq("prdata", {24'd0, prdata[e.dut]}, {24'd0, e.rdata});
      end else begin
        check_eq("pslverr_wait", {31'd0, pslverr[d]}, 32'd0);
        waits++;
      end
      @(posedge PCLK); #1;
    end
    if (!done) begin
      e = exp_q.pop_front();
      check_eq("ready_timeout", waits, ws_of(d));
    end
    psel[d] = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic apb_abort(input int d, input logic [7:0] addr, input logic [7:0] data, input int n_acc);
    psel[d] = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    for (int c = 0; c < n_acc; c++) begin
      @(negedge PCLK);
      check_eq("abort_pready", {31'd0, pready[d]}, 32'd0);
      @(posedge PCLK); #1;
    end
    psel[d] = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    check_eq("abort_idle_pready", {31'd0, pready[d]}, 32'd0);
    @(posedge PCLK); #1;
  endtask

  task automatic do_reset();
    PRESET = 1'b1;
    @(negedge PCLK);
    check_eq("rst_pready", {30'd0, pready}, 32'd0);
    check_eq("rst_pslverr", {30'd0, pslverr}, 32'd0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    clear_model();
    check_eq("rst_prdata0", {24'd0, prdata[0]}, 32'd0);
    check_eq("rst_prdata1", {24'd0, prdata[1]}, 32'd0);
  endtask

  initial begin
    PRESET = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; psel = 2'b00; PADDR = 8'h00; PWDATA = 8'h00;
    clear_model();
    @(posedge PCLK); #1;
    do_reset();

    // Basic write/read, then out-of-range accesses and a neighbour at the top address.
    apb_xfer(0, 1'b1, 8'h10, 8'hA5);
    apb_xfer(0, 1'b0, 8'h10, 8'h00);
    apb_xfer(0, 1'b1, 8'h3F, 8'h5A);
    apb_xfer(0, 1'b1, 8'h40, 8'h3C);
    apb_xfer(0, 1'b0, 8'h40, 8'h00);
    apb_xfer(0, 1'b0, 8'h3F, 8'h00);
    apb_xfer(0, 1'b0, 8'hFF, 8'h00);

    // Wait-state instance: completion after two stalled access cycles.
    apb_xfer(1, 1'b1, 8'h10, 8'hA5);
    apb_xfer(1, 1'b0, 8'h10, 8'h00);
    apb_xfer(1, 1'b1, 8'h41, 8'h99);

    // Aborted write never commits.
    apb_abort(1, 8'h20, 8'h77, 1);
    apb_xfer(1, 1'b0, 8'h20, 8'h00);

    // PENABLE without setup is ignored.
    psel[0] = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 8'h06; PWDATA = 8'hEE;
    for (int c = 0; c < 2; c++) begin
      @(negedge PCLK);
      check_eq("nosetup_pready", {31'd0, pready[0]}, 32'd0);
      @(posedge PCLK); #1;
    end
    psel[0] = 1'b0; PENABLE = 1'b0;
    apb_xfer(0, 1'b0, 8'h06, 8'h00);

    // Reset during the access phase of a write.
    apb_xfer(0, 1'b1, 8'h05, 8'h99);
    psel[0] = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h05; PWDATA = 8'h11;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    do_reset();
    psel[0] = 1'b0; PENABLE = 1'b0;
    apb_xfer(0, 1'b0, 8'h05, 8'h00);
    apb_xfer(1, 1'b0, 8'h10, 8'h00);

    // Back-to-back transfers with no idle cycle.
    for (int i = 0; i < 4; i++) apb_xfer(0, 1'b1, i[7:0], i[7:0] + 8'd1);
    for (int i = 0; i < 4; i++) apb_xfer(0, 1'b0, i[7:0], 8'h00);

    // Randomised traffic on both instances.
    for (int i = 0; i < 24; i++) begin
      apb_xfer(i % 2, $urandom_range(0, 1) == 1, 8'($urandom_range(0, 70)), 8'($urandom_range(0, 255)));
    end

    check_eq("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
